// File: rtl/sram_responder.sv
// sram_responder
// On-chip stand-in for the external asynchronous SRAM. It answers the CPU's
// memory pins: writes commit on the sampling edge with byte-lane masking,
// and reads drive the shared Data bus from a register loaded on the
// sampling edge. After every reset the whole array is filled with
// init_word(i). Busy is held high during this fill.
//
// Ports:
//   Clk         system clock, rising edge
//   Reset       synchronous reset, active-low
//   CE, UB, LB  chip / upper-byte / lower-byte enables, active-low
//   OE, WE      output / write enables, active-low (WE wins over OE)
//   ADDR[19:0]  word address; only ADDR[ADDR_W-1:0] are implemented
//   Data[15:0]  shared bidirectional data bus
//   Busy        high while the post-reset fill runs
//   Access_Err  one-cycle pulse after an access with ADDR[19:ADDR_W] != 0
//
// Parameters:
//   ADDR_W      implemented address bits; DEPTH = 2**ADDR_W words
//
// Build option:
//   SRAM_INIT_PROG_EN  when defined, the fill places a three-word
//                      self-incrementing loop at address 0. Otherwise the
//                      array is filled with zeros.

module sram_responder #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        CE,
  input  logic        UB,
  input  logic        LB,
  input  logic        OE,
  input  logic        WE,
  input  logic [19:0] ADDR,
  inout  logic [15:0] Data,
  output logic        Busy,
  output logic        Access_Err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_RD,
    S_WR
  } state_t;

  state_t state, state_d;

  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] init_cnt;
  logic [15:0]       init_data;
  logic [15:0]       rd_q;
  logic              access_err;

  logic [ADDR_W-1:0] word_addr;
  logic              in_range;
  logic              wr_req;
  logic              rd_req;
  logic              wr_go;
  logic              rd_go;
  logic              drv_hi;
  logic              drv_lo;

  assign word_addr = ADDR[ADDR_W-1:0];
  assign in_range  = (ADDR >> ADDR_W) == 20'd0;
  assign wr_req    = !CE && !WE;
  assign rd_req    = !CE && !OE && WE;

  // Fill pattern for the post-reset initialisation.
  always_comb begin
    init_data = 16'h0000;
`ifdef SRAM_INIT_PROG_EN
    case (32'(init_cnt))
      32'd0:   init_data = 16'h5020;
      32'd1:   init_data = 16'h1021;
      32'd2:   init_data = 16'h0FFE;
      default: init_data = 16'h0000;
    endcase
`endif
  end

  // Next-state logic and accepted-access and pin-drive decodes.
  always_comb begin
    state_d = state;
    wr_go   = 1'b0;
    rd_go   = 1'b0;
    drv_hi  = 1'b0;
    drv_lo  = 1'b0;
    case (state)
      S_INIT: begin
        if (init_cnt == '1) state_d = S_IDLE;
      end
      S_IDLE, S_RD: begin
        wr_go = wr_req;
        rd_go = rd_req;
        if (wr_req)      state_d = S_WR;
        else if (rd_req) state_d = S_RD;
        else             state_d = S_IDLE;
      end
      S_WR: begin
        wr_go   = wr_req;
        state_d = wr_req ? S_WR : S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
    // Drive is gated directly by the live pins, so releasing CE/OE or
    // asserting WE turns the bus around without waiting for an edge.
    if (state == S_RD && rd_req) begin
      drv_hi = !UB;
      drv_lo = !LB;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state      <= S_INIT;
      init_cnt   <= '0;
      rd_q       <= '0;
      access_err <= 1'b0;
    end else begin
      state      <= state_d;
      if (state == S_INIT) init_cnt <= init_cnt + ADDR_W'(1);
      if (rd_go) rd_q <= in_range ? mem[word_addr] : 16'h0000;
      access_err <= (wr_go || rd_go) && !in_range;
    end
  end

  // Storage has no reset of its own; it is rewritten by the fill after
  // every reset release.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      if (state == S_INIT) begin
        mem[init_cnt] <= init_data;
      end else if (wr_go && in_range) begin
        if (!LB) mem[word_addr][7:0]  <= Data[7:0];
        if (!UB) mem[word_addr][15:8] <= Data[15:8];
      end
    end
  end

  assign Data[15:8] = drv_hi ? rd_q[15:8] : 8'hzz;
  assign Data[7:0]  = drv_lo ? rd_q[7:0]  : 8'hzz;

  assign Busy       = (state == S_INIT);
  assign Access_Err = access_err;

endmodule

// File: tb/tb_sram_responder.sv
// Testbench for sram_responder with ADDR_W=4. The bus has pull-ups, so an
// undriven lane reads as all ones. Expected read data is taken from a local
// memory model. It is pushed into a queue when a read is issued, and it is
// popped and compared once the DUT drives the bus.

module tb_sram_responder;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic        clk      = 1'b0;
  logic        reset_n  = 1'b0;
  logic        ce       = 1'b1;
  logic        ub       = 1'b1;
  logic        lb       = 1'b1;
  logic        oe       = 1'b1;
  logic        we       = 1'b1;
  logic [19:0] addr     = '0;
  logic        tb_drive = 1'b0;
  logic [15:0] tb_data  = '0;
  wire  [15:0] data_bus;
  logic        busy;
  logic        access_err;

  int unsigned num_checks = 0;
  int unsigned num_errors = 0;

  logic [15:0] model [DEPTH];

  typedef struct {
    string       tag;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];

  assign data_bus = tb_drive ? tb_data : 16'hzzzz;
  for (genvar g = 0; g < 16; g++) begin : g_pull
    pullup (data_bus[g]);
  end

  always #5 clk = ~clk;

  sram_responder #(.ADDR_W(ADDR_W)) dut (
    .Clk        (clk),
    .Reset      (reset_n),
    .CE         (ce),
    .UB         (ub),
    .LB         (lb),
    .OE         (oe),
    .WE         (we),
    .ADDR       (addr),
    .Data       (data_bus),
    .Busy       (busy),
    .Access_Err (access_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] init_word(input int unsigned i);
    init_word = 16'h0000;
`ifdef SRAM_INIT_PROG_EN
    if (i == 0) init_word = 16'h5020;
    if (i == 1) init_word = 16'h1021;
    if (i == 2) init_word = 16'h0FFE;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    ce = 1'b1; oe = 1'b1; we = 1'b1; ub = 1'b1; lb = 1'b1;
    tb_drive = 1'b0;
  endtask

  // Count edges until Busy drops. Optionally hammer a write to address 7
  // during the fill, which must be ignored.
  task automatic wait_init(input logic poke);
    int unsigned cnt = 0;
    for (int n = 1; n <= 100; n++) begin
      if (poke) begin
        ce = 1'b0; we = 1'b0; oe = 1'b1; ub = 1'b0; lb = 1'b0;
        addr = 20'h00007; tb_drive = 1'b1; tb_data = 16'h1111;
      end
      step();
      if (!busy) begin
        cnt = n;
        break;
      end
    end
    go_idle();
    check("init_len", cnt, DEPTH);
    for (int i = 0; i < DEPTH; i++) model[i] = init_word(i);
  endtask

  task automatic rd(input logic [19:0] a, input logic u, input logic l);
    logic        oor;
    logic [15:0] w;
    exp_t        e;
    oor = (a >> ADDR_W) != 20'd0;
    w   = oor ? 16'h0000 : model[a[ADDR_W-1:0]];
    ce = 1'b0; oe = 1'b0; we = 1'b1; ub = u; lb = l; addr = a;
    tb_drive = 1'b0;
    exp_q.push_back('{$sformatf("rd_%0h_u%0d_l%0d", a, u, l),
                      {u ? 8'hFF : w[15:8], l ? 8'hFF : w[7:0]}});
    step();
    check($sformatf("rd_err_%0h", a), access_err, oor);
    e = exp_q.pop_front();
    check(e.tag, data_bus, e.data);
  endtask

  task automatic wr(input logic [19:0] a, input logic [15:0] d, input logic u, input logic l);
    logic oor;
    oor = (a >> ADDR_W) != 20'd0;
    ce = 1'b0; we = 1'b0; oe = 1'b1; ub = u; lb = l; addr = a;
    tb_drive = 1'b1; tb_data = d;
    step();
    check($sformatf("wr_err_%0h", a), access_err, oor);
    if (!oor) begin
      if (!l) model[a[ADDR_W-1:0]][7:0]  = d[7:0];
      if (!u) model[a[ADDR_W-1:0]][15:8] = d[15:8];
    end
    go_idle();
    step();
    check("wr_err_clr", access_err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    go_idle();
    reset_n = 1'b0;
    step();
    step();
    check("rst_busy", busy, 1'b1);
    check("rst_err", access_err, 1'b0);
    check("rst_bus", data_bus, 16'hFFFF);

    // Fill length, then read back every word
    reset_n = 1'b1;
    wait_init(1'b0);
    for (int i = 0; i < DEPTH; i++) rd(20'(i), 1'b0, 1'b0);
    go_idle();
    step();

    // Word write then read, OE release is combinational
    wr(20'h00005, 16'hBEEF, 1'b0, 1'b0);
    rd(20'h00005, 1'b0, 1'b0);
    oe = 1'b1;
    #1;
    check("oe_release", data_bus, 16'hFFFF);
    go_idle();
    step();

    // Byte lanes
    wr(20'h00005, 16'h1234, 1'b1, 1'b0);
    rd(20'h00005, 1'b0, 1'b1);
    rd(20'h00005, 1'b0, 1'b0);
    go_idle();
    step();

    // Read-to-write turnaround and OE/WE contention
    rd(20'h00003, 1'b0, 1'b0);
    we = 1'b0; ub = 1'b1; lb = 1'b1;
    #1;
    check("we_in_rd_no_drive", data_bus, 16'hFFFF);
    step();
    ub = 1'b0; lb = 1'b0; tb_drive = 1'b1; tb_data = 16'hA5A5;
    step();
    model[3] = 16'hA5A5;
    tb_drive = 1'b0;
    #1;
    check("contention_no_drive", data_bus, 16'hFFFF);
    go_idle();
    step();
    rd(20'h00003, 1'b0, 1'b0);
    go_idle();
    step();

    // Out of range
    rd(20'h00100, 1'b0, 1'b0);
    go_idle();
    step();
    check("oor_rd_err_clr", access_err, 1'b0);
    wr(20'h00100, 16'hFFFF, 1'b0, 1'b0);
    rd(20'h00000, 1'b0, 1'b0);

    // Reset in the middle of a read
    rd(20'h00005, 1'b0, 1'b0);
    reset_n = 1'b0;
    step();
    check("midrd_bus", data_bus, 16'hFFFF);
    check("midrd_busy", busy, 1'b1);
    check("midrd_err", access_err, 1'b0);
    step();
    reset_n = 1'b1;
    wait_init(1'b1);
    rd(20'h00000, 1'b0, 1'b0);
    rd(20'h00001, 1'b0, 1'b0);
    rd(20'h00002, 1'b0, 1'b0);
    rd(20'h00005, 1'b0, 1'b0);
    rd(20'h00007, 1'b0, 1'b0);
    go_idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
# sram_responder

Synthesizable on-chip stand-in for the external asynchronous SRAM, and the responder side of the CPU's memory pin interface. It samples CE, UB, LB, OE, WE, ADDR and Data each clock, commits writes with byte-lane masking, and returns read data on the shared Data bus one cycle after a read is sampled. After every reset it initializes its storage, holding Busy high until it is ready, so the CPU runs against deterministic memory without the board SRAM.

## Interface
- ADDR_W, default 10: implemented address bits; DEPTH = 2^ADDR_W 16-bit words.
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- CE  in  1  chip enable, active-low.
- UB  in  1  upper byte (Data[15:8]) enable, active-low.
- LB  in  1  lower byte (Data[7:0]) enable, active-low.
- OE  in  1  output enable, active-low.
- WE  in  1  write enable, active-low.
- ADDR  in  20  word address.
- Data  inout  16  shared data bus; driven only as specified under Operation, otherwise high-Z.
- Busy  out  1  high while initialization runs; bus activity is ignored.
- Access_Err  out  1  one-cycle pulse on any access with ADDR[19:ADDR_W] != 0.

## Operation
- States:
  - INIT: fill the memory.
  - IDLE: wait for an access.
  - RD: a read is active and the block drives data.
  - WR: a write is active.
- INIT:
  - Init counter starts at 0 and writes init_word(counter) each cycle.
  - After address DEPTH-1 is written, go to IDLE.
  - Busy=1 throughout. Pins are ignored and Data stays high-Z.
- Write condition: CE=0 and WE=0, in IDLE, RD or WR.
  - Each selected byte lane of Data is written to mem[ADDR] on that edge. LB=0 selects [7:0]; UB=0 selects [15:8].
  - State goes to WR. A write is repeated every cycle WE stays low.
  - WE has priority over OE: if OE=0 and WE=0 together, the write happens and the block never drives Data.
- Read condition: CE=0, OE=0, WE=1, in IDLE or RD.
  - rd_q <= mem[ADDR] and state goes to RD.
  - rd_q is reloaded every cycle in RD, so Data always reflects the ADDR sampled on the previous edge.
- Data drive:
  - Lane [15:8] is driven with rd_q[15:8] only when state=RD, CE=0, OE=0, WE=1 and UB=0.
  - Lane [7:0] is driven the same way, gated by LB=0.
  - The pin gating is combinational, so releasing CE, OE or WE stops the drive in the same cycle.
  - An unselected lane stays high-Z.
- Return to IDLE:
  - From RD, when the sampled CE=1 or OE=1 and no write is requested.
  - From WR, when the sampled WE=1 or CE=1.
- Out of range (ADDR[19:ADDR_W] != 0):
  - A read loads rd_q=16'h0000.
  - A write is dropped.
  - Access_Err=1 for the cycle after each sampled out-of-range access edge.
- Reset=0 sampled on any edge, from any state:
  - state=INIT, counter=0, Busy=1, Access_Err=0, Data drive off.
  - Holding Reset low keeps the counter at 0.
  - Memory is fully re-initialized after release, so previous contents are lost.

## Timing
- Reset values: Busy=1, Access_Err=0, Data high-Z, state INIT, rd_q=0.
- Init length:
  - The first INIT write happens on the first edge with Reset=1.
  - Busy falls after exactly DEPTH edges with Reset=1.
  - The first access is accepted on the following edge.
- Read latency: 1 cycle. A read sampled at edge N is driven on Data from edge N until the pins release.
- Write latency: 0 cycles. A read of the same address sampled at edge N+1 returns the new data at N+1.
- Back-to-back read to write: a write sampled while in RD turns the drive off immediately via WE=0.

## Configuration
- SRAM_INIT_PROG_EN:
  - Defined: init_word(i) is 16'h5020 (i=0), 16'h1021 (i=1), 16'h0FFE (i=2), and 16'h0000 otherwise. This loads a self-incrementing loop at address 0.
  - Undefined: init_word(i)=16'h0000 for all i.
  - Init duration is DEPTH cycles in both cases.

## Test plan
- Init (ADDR_W=4, macro off):
  - Stimulus: Reset=0 for 2 cycles, then 1.
  - Response: Busy=1 for exactly 16 edges, then 0. Reading addresses 0..15 returns 16'h0000.
- Word write then read:
  - Stimulus: CE=WE=UB=LB=0, ADDR=0x00005, Data=16'hBEEF for one cycle; then CE=OE=0, WE=1.
  - Response: Data=16'hBEEF from the read-sample edge. Raising OE makes Data high-Z in the same cycle.
- Byte lanes:
  - Stimulus: write 16'h1234 to 0x00005 with LB=0, UB=1; then read with UB=0, LB=1.
  - Response: Data[15:8]=8'hBE and Data[7:0] is high-Z. A full read returns 16'hBE34.
- Contention:
  - Stimulus: OE=0 and WE=0 together, writing 16'hA5A5 to 0x00003.
  - Response: the responder never drives Data. A later read returns 16'hA5A5.
- Out of range (ADDR_W=4):
  - Stimulus: ADDR=20'h00100; a read, then a write of 16'hFFFF.
  - Response: the read drives 16'h0000 and Access_Err pulses once per access. mem[0] is unchanged.
- Reset mid-read, macro on:
  - Stimulus: Reset=0 while in RD.
  - Response: Data goes high-Z at the next edge and Busy=1. After init, reading address 0 gives 16'h5020, address 1 gives 16'h1021, and address 2 gives 16'h0FFE.
